// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    OFF      = 3'b001,
    ON       = 3'b010,
    STOPPING = 3'b100
  } rx_ctrl_state_t;

  localparam int unsigned RX_FIFO_DEPTH    = 16;
  localparam int unsigned RX_TIMEOUT_BAUDS = 40;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head word, flush, and occupancy level.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [AW:0]      level,
  output logic             rd_fire,
  output logic             wr_drop
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_n;
  logic             full;
  logic             do_write;

  assign full     = (level == (AW+1)'(DEPTH));
  assign rd_valid = (level != '0);
  assign rd_fire  = rd_en && rd_valid && !flush;
  assign do_write = wr_en && !flush && (!full || rd_fire);
  assign wr_drop  = wr_en && !flush && full && !rd_fire;
  assign rd_ptr_n = rd_fire ? rd_ptr + 1'b1 : rd_ptr;

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_n;
      case ({do_write, rd_fire})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // The head register tracks whichever slot rd_ptr points at after this edge;
  // a write landing on that slot (empty buffer, or one entry being read) bypasses memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (!flush) begin
      if (do_write && (wr_ptr == rd_ptr_n)) rd_data <= wr_data;
      else if (rd_fire)                     rd_data <= mem[rd_ptr_n];
    end
  end

endmodule

// File: rtl/rx_ctrl.sv
// Receive controller: enable FSM, receive buffer, overrun/idle-timeout flags and interrupt.
module rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH         = RX_FIFO_DEPTH,
  parameter int unsigned TIMEOUT_BAUDS = RX_TIMEOUT_BAUDS,
  localparam int unsigned AW           = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          cfg_rx_en_i,
  input  logic [AW:0]   cfg_watermark_i,
  input  logic          flush_i,
  input  logic          baud_tick_i,
  output logic          eng_en_o,
  input  logic          eng_busy_i,
  input  logic [7:0]    eng_data_i,
  input  logic          eng_wen_i,
  output logic [7:0]    rd_data_o,
  output logic          rd_valid_o,
  input  logic          rd_ready_i,
  output logic [AW:0]   level_o,
  output logic          rx_active_o,
  output logic          overrun_o,
  input  logic          overrun_clr_i,
  output logic          timeout_o,
  output logic          irq_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_BAUDS + 1);

  rx_ctrl_state_t state;
  logic           rd_fire;
  logic           wr_drop;
  logic [TW-1:0]  to_cnt;
  logic [TW-1:0]  to_cnt_n;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk_i),
    .rst_n    (reset_n_i),
    .flush    (flush_i),
    .wr_en    (eng_wen_i),
    .wr_data  (eng_data_i),
    .rd_en    (rd_ready_i),
    .rd_data  (rd_data_o),
    .rd_valid (rd_valid_o),
    .level    (level_o),
    .rd_fire  (rd_fire),
    .wr_drop  (wr_drop)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= OFF;
      eng_en_o    <= 1'b0;
      rx_active_o <= 1'b0;
    end else begin
      case (state)
        OFF: begin
          if (cfg_rx_en_i) begin
            state       <= ON;
            eng_en_o    <= 1'b1;
            rx_active_o <= 1'b1;
          end
        end
        ON: begin
          if (!cfg_rx_en_i) begin
            eng_en_o <= 1'b0;
            if (eng_busy_i) begin
              state       <= STOPPING;
              rx_active_o <= 1'b1;
            end else begin
              state       <= OFF;
              rx_active_o <= 1'b0;
            end
          end
        end
        STOPPING: begin
          if (cfg_rx_en_i) begin
            state       <= ON;
            eng_en_o    <= 1'b1;
            rx_active_o <= 1'b1;
          end else if (!eng_busy_i) begin
            state       <= OFF;
            eng_en_o    <= 1'b0;
            rx_active_o <= 1'b0;
          end
        end
        default: begin
          state       <= OFF;
          eng_en_o    <= 1'b0;
          rx_active_o <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    to_cnt_n = to_cnt;
    if (flush_i || rd_fire || eng_wen_i || level_o == '0)
      to_cnt_n = '0;
    else if (baud_tick_i && to_cnt != TW'(TIMEOUT_BAUDS))
      to_cnt_n = to_cnt + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      to_cnt    <= '0;
      timeout_o <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      to_cnt <= to_cnt_n;
      if (flush_i || rd_fire || level_o == '0) timeout_o <= 1'b0;
      else if (to_cnt_n == TW'(TIMEOUT_BAUDS)) timeout_o <= 1'b1;
      // A new drop outranks a clear arriving on the same edge.
      if (wr_drop)            overrun_o <= 1'b1;
      else if (overrun_clr_i) overrun_o <= 1'b0;
    end
  end

  assign irq_o = ((cfg_watermark_i != '0) && (level_o >= cfg_watermark_i))
               || timeout_o || overrun_o;

endmodule

// File: tb/tb_rx_ctrl.sv
// Directed self-checking bench for rx_ctrl with a 4-entry buffer and 4-baud timeout.
module tb_rx_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cfg_rx_en;
  logic [AW:0]   cfg_watermark;
  logic          flush;
  logic          baud_tick;
  logic          eng_en;
  logic          eng_busy;
  logic [7:0]    eng_data;
  logic          eng_wen;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [AW:0]   level;
  logic          rx_active;
  logic          overrun;
  logic          overrun_clr;
  logic          timeout;
  logic          irq;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  rx_ctrl #(
    .DEPTH         (DEPTH),
    .TIMEOUT_BAUDS (4)
  ) dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .cfg_rx_en_i     (cfg_rx_en),
    .cfg_watermark_i (cfg_watermark),
    .flush_i         (flush),
    .baud_tick_i     (baud_tick),
    .eng_en_o        (eng_en),
    .eng_busy_i      (eng_busy),
    .eng_data_i      (eng_data),
    .eng_wen_i       (eng_wen),
    .rd_data_o       (rd_data),
    .rd_valid_o      (rd_valid),
    .rd_ready_i      (rd_ready),
    .level_o         (level),
    .rx_active_o     (rx_active),
    .overrun_o       (overrun),
    .overrun_clr_i   (overrun_clr),
    .timeout_o       (timeout),
    .irq_o           (irq)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_eng_en"},    32'(eng_en),    0);
    check_eq({tag, "_rx_active"}, 32'(rx_active), 0);
    check_eq({tag, "_rd_valid"},  32'(rd_valid),  0);
    check_eq({tag, "_overrun"},   32'(overrun),   0);
    check_eq({tag, "_timeout"},   32'(timeout),   0);
    check_eq({tag, "_irq"},       32'(irq),       0);
    check_eq({tag, "_level"},     32'(level),     0);
    check_eq({tag, "_rd_data"},   32'(rd_data),   0);
  endtask

  initial begin
    logic [7:0] seq [4];
    reset_n = 1'b1; cfg_rx_en = 1'b0; cfg_watermark = '0; flush = 1'b0;
    baud_tick = 1'b0; eng_busy = 1'b0; eng_data = '0; eng_wen = 1'b0;
    rd_ready = 1'b0; overrun_clr = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) step();
    reset_n = 1'b1;

    cfg_rx_en = 1'b1;
    step();
    check_eq("on_eng_en", 32'(eng_en), 1);
    check_eq("on_rx_active", 32'(rx_active), 1);

    // In-order delivery with a stalled consumer.
    eng_wen = 1'b1; eng_data = 8'h11; step();
    check_eq("first_valid", 32'(rd_valid), 1);
    check_eq("first_data", 32'(rd_data), 32'h11);
    eng_data = 8'h22; step();
    eng_data = 8'h33; step();
    eng_wen = 1'b0;
    check_eq("lvl3", 32'(level), 3);
    check_eq("hold_data", 32'(rd_data), 32'h11);
    rd_ready = 1'b1;
    step(); check_eq("rd_22", 32'(rd_data), 32'h22); check_eq("lvl2", 32'(level), 2);
    step(); check_eq("rd_33", 32'(rd_data), 32'h33); check_eq("lvl1", 32'(level), 1);
    step(); check_eq("drained_valid", 32'(rd_valid), 0); check_eq("lvl0", 32'(level), 0);
    rd_ready = 1'b0;

    // Full buffer, overrun, and full read+write.
    cfg_watermark = 3'd4;
    eng_wen = 1'b1;
    for (int i = 0; i < 4; i++) begin
      eng_data = 8'hA0 + 8'(i);
      step();
    end
    check_eq("full_lvl", 32'(level), 4);
    check_eq("wm_irq", 32'(irq), 1);
    check_eq("no_ovr_yet", 32'(overrun), 0);
    cfg_watermark = '0;
    #1 check_eq("wm_off_irq", 32'(irq), 0);
    eng_data = 8'hA4; step();
    eng_wen = 1'b0;
    check_eq("ovr_set", 32'(overrun), 1);
    check_eq("ovr_irq", 32'(irq), 1);
    check_eq("ovr_lvl", 32'(level), 4);
    check_eq("ovr_head", 32'(rd_data), 32'hA0);
    overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
    check_eq("ovr_clr", 32'(overrun), 0);
    eng_wen = 1'b1; eng_data = 8'hA5; rd_ready = 1'b1; step();
    eng_wen = 1'b0;
    check_eq("rw_full_ovr", 32'(overrun), 0);
    check_eq("rw_full_lvl", 32'(level), 4);
    seq[0] = 8'hA1; seq[1] = 8'hA2; seq[2] = 8'hA3; seq[3] = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_data", 32'(rd_data), 32'(seq[i]));
      step();
    end
    check_eq("drain_empty", 32'(rd_valid), 0);
    rd_ready = 1'b0;

    // Idle timeout after four quiet baud ticks.
    eng_wen = 1'b1; eng_data = 8'h77; step(); eng_wen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      baud_tick = 1'b1; step(); baud_tick = 1'b0;
      if (i == 2) check_eq("to_before", 32'(timeout), 0);
    end
    check_eq("to_set", 32'(timeout), 1);
    check_eq("to_irq", 32'(irq), 1);
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    check_eq("to_clr", 32'(timeout), 0);
    check_eq("to_lvl", 32'(level), 0);

    // Flush with a concurrent write.
    eng_wen = 1'b1; eng_data = 8'h01; step();
    eng_data = 8'h02; step();
    check_eq("pre_flush_lvl", 32'(level), 2);
    eng_data = 8'h03; flush = 1'b1; step();
    flush = 1'b0; eng_wen = 1'b0;
    check_eq("flush_lvl", 32'(level), 0);
    check_eq("flush_valid", 32'(rd_valid), 0);
    check_eq("flush_ovr", 32'(overrun), 0);

    // Disable while busy, re-enable, then finish a frame while stopping.
    eng_busy = 1'b1; cfg_rx_en = 1'b0; step();
    check_eq("stop_eng_en", 32'(eng_en), 0);
    check_eq("stop_active", 32'(rx_active), 1);
    cfg_rx_en = 1'b1; step();
    check_eq("reon_eng_en", 32'(eng_en), 1);
    cfg_rx_en = 1'b0; step();
    check_eq("stop2_eng_en", 32'(eng_en), 0);
    eng_wen = 1'b1; eng_data = 8'h5A; eng_busy = 1'b0; step();
    eng_wen = 1'b0;
    check_eq("off_active", 32'(rx_active), 0);
    check_eq("stop_byte_lvl", 32'(level), 1);
    check_eq("stop_byte", 32'(rd_data), 32'h5A);

    // Reset mid-STOPPING with data buffered and irq asserted.
    cfg_rx_en = 1'b1; step();
    cfg_rx_en = 1'b0; eng_busy = 1'b1; step();
    check_eq("stop3_active", 32'(rx_active), 1);
    cfg_watermark = 3'd1;
    #1 check_eq("pre_rst_irq", 32'(irq), 1);
    #2 reset_n = 1'b0;
    #1 check_all_zero("async_rst");
    eng_busy = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    check_eq("post_rst_active", 32'(rx_active), 0);
    check_eq("post_rst_lvl", 32'(level), 0);
    cfg_rx_en = 1'b1; step();
    check_eq("resume_active", 32'(rx_active), 1);
    check_eq("resume_eng_en", 32'(eng_en), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_ctrl.md
RX_CTRL -- requirements
Module: rx_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning receive buffer entries; power of two, minimum 4.
REQ-002 The block SHALL have parameter TIMEOUT_BAUDS, default 40, meaning the idle-timeout threshold in baud ticks.
REQ-003 The block SHALL have local constant AW = $clog2(DEPTH); level-type ports are AW+1 bits wide.
REQ-004 The block SHALL have these ports (name direction width meaning):
- clk_i  in  1  the single clock.
- reset_n_i  in  1  reset, asynchronous, active-low.
- cfg_rx_en_i  in  1  software receive enable.
- cfg_watermark_i  in  AW+1  irq level threshold; 0 disables the term.
- flush_i  in  1  single-cycle buffer flush.
- baud_tick_i  in  1  one-cycle pulse per bit period.
- eng_en_o  out  1  start-detect enable to the receive engine.
- eng_busy_i  in  1  engine is mid-frame.
- eng_data_i  in  8  received byte.
- eng_wen_i  in  1  received-byte write strobe.
- rd_data_o  out  8  head byte.
- rd_valid_o  out  1  buffer non-empty.
- rd_ready_i  in  1  consumer accepts head byte.
- level_o  out  AW+1  buffered byte count.
- rx_active_o  out  1  FSM not in OFF.
- overrun_o  out  1  sticky dropped-byte flag.
- overrun_clr_i  in  1  clears overrun_o.
- timeout_o  out  1  sticky idle-timeout flag.
- irq_o  out  1  combined interrupt.

Function
REQ-005 FSM states SHALL be OFF, ON, STOPPING; eng_en_o SHALL be 1 only in ON; rx_active_o SHALL be 1 in ON and STOPPING.
REQ-006 OFF->ON SHALL occur on the clock after cfg_rx_en_i=1; ON->OFF on cfg_rx_en_i=0 with eng_busy_i=0; ON->STOPPING on cfg_rx_en_i=0 with eng_busy_i=1; STOPPING->OFF when eng_busy_i=0; STOPPING->ON if cfg_rx_en_i returns to 1.
REQ-007 Bytes strobed via eng_wen_i SHALL be accepted in every state, so frames completing during STOPPING are kept.
REQ-008 Write handling SHALL follow these rules:
- A write that is not full SHALL store eng_data_i.
- A byte written at edge N SHALL show rd_valid_o=1 and rd_data_o equal to that byte after edge N.
- rd_data_o SHALL be registered head data.
REQ-009 A read SHALL occur when rd_valid_o and rd_ready_i are both 1; rd_data_o SHALL hold stable while rd_valid_o=1 and rd_ready_i=0.
REQ-010 Simultaneous read and write SHALL leave level_o unchanged, including when full, in which case the write is accepted with no overrun.
REQ-011 A write when full without a simultaneous read SHALL be dropped and SHALL set overrun_o on the next clock.
REQ-012 overrun_o SHALL clear on overrun_clr_i; a simultaneous new overrun SHALL win, leaving it set.
REQ-013 Pointers SHALL wrap modulo DEPTH; level_o SHALL range 0..DEPTH and never wrap.
REQ-014 flush_i SHALL empty the buffer, zero level_o, clear timeout_o and reset the timeout counter; a concurrent write SHALL be discarded without overrun; overrun_o SHALL be unaffected.
REQ-015 The timeout counter SHALL behave as follows:
- It SHALL increment on baud_tick_i while level_o>0 and no read or write occurs that cycle.
- It SHALL reset to 0 on any read, write, or level_o=0.
- It SHALL saturate at TIMEOUT_BAUDS.
REQ-016 When the timeout counter reaches TIMEOUT_BAUDS, timeout_o SHALL set; it SHALL clear on the next read handshake, on flush, or when level_o becomes 0.
REQ-017 irq_o SHALL be (cfg_watermark_i!=0 AND level_o>=cfg_watermark_i) OR timeout_o OR overrun_o, combinational from registered state only.

Reset
REQ-018 Asserting reset_n_i=0 SHALL immediately force:
- FSM to OFF.
- eng_en_o, rx_active_o, rd_valid_o, overrun_o, timeout_o and irq_o to 0.
- level_o to 0 and rd_data_o to 8'h00.
- pointers and timeout counter to 0.
REQ-019 Reset SHALL discard buffered bytes, including when asserted mid-frame or mid-handshake.
REQ-020 Deassertion SHALL be synchronized externally; the block SHALL resume from OFF on the first clock after release.

Structure
REQ-021 Package uart_pkg SHALL hold rx_ctrl_state_t (OFF, ON, STOPPING, one-hot) and defaults RX_FIFO_DEPTH=16 and RX_TIMEOUT_BAUDS=40.
REQ-022 Buffer storage, pointers and level SHALL be one sub-module, sync_fifo (parameters WIDTH=8, DEPTH), instantiated once; FSM, flags, timeout and irq logic SHALL live in rx_ctrl.

Verification
REQ-023 With DEPTH=4, write bytes 0x11, 0x22, 0x33 with rd_ready_i=0, then hold rd_ready_i=1 -> level_o reaches 3; reads return 0x11, 0x22, 0x33 in order; rd_valid_o then falls to 0.
REQ-024 With DEPTH=4, fill with 0xA0..0xA3 then write 0xA4 -> 0xA4 dropped, overrun_o=1, irq_o=1, level_o=4; repeat the full-buffer write with a concurrent read -> no overrun and level_o stays 4.
REQ-025 Hold cfg_rx_en_i=0 while eng_busy_i=1, then strobe 0x5A and drop eng_busy_i -> STOPPING with eng_en_o=0; 0x5A is buffered; state reaches OFF the next clock.
REQ-026 With TIMEOUT_BAUDS=4, write one byte, then issue 4 baud ticks with no traffic -> timeout_o=1 after the 4th tick; one read clears timeout_o and level_o becomes 0.
REQ-027 With 2 bytes buffered, assert flush_i with a concurrent eng_wen_i, then pull reset_n_i low mid-STOPPING -> the flush gives level_o=0 with no overrun; the reset immediately gives all outputs 0 and state OFF.
